// File: rtl/regfile_write_arbiter.sv
// Two-source arbiter for the single register-file write port.
// Port 0 has fixed priority; a starvation guard forces one port-1 grant.
module regfile_write_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              last_grant,
  output logic [7:0]        zero_drops
);

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE1 = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              last_grant_q, last_grant_d;
  logic [7:0]        zero_drops_q, zero_drops_d;

  logic              xfer0, xfer1;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  always_comb begin
    req0_ready = 1'b1;
    req1_ready = !req0_valid;
    if (state_q == FORCE1) begin
      req0_ready = 1'b0;
      req1_ready = 1'b1;
    end
  end

  // The ready terms make the two transfers mutually exclusive.
  assign xfer0    = req0_valid && req0_ready;
  assign xfer1    = req1_valid && req1_ready;
  assign win_addr = xfer1 ? req1_addr : req0_addr;
  assign win_data = xfer1 ? req1_data : req0_data;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      NORMAL: begin
        if (req0_valid && req1_valid) begin
          if (starve_cnt_q == STARVE_MAX) begin
            state_d      = FORCE1;
            starve_cnt_d = '0;
          end else begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end else begin
          starve_cnt_d = '0;
        end
      end
      FORCE1: begin
        // A dropped req1 here is a protocol violation; leave without writing.
        if (xfer1 || !req1_valid) state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  always_comb begin
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    last_grant_d = last_grant_q;
    zero_drops_d = zero_drops_q;
    if (xfer0 || xfer1) begin
      rf_we_d      = |win_addr;
      rf_waddr_d   = win_addr;
      rf_wdata_d   = win_data;
      last_grant_d = xfer1;
      if (~|win_addr && zero_drops_q != 8'hFF) zero_drops_d = zero_drops_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= NORMAL;
      starve_cnt_q <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      last_grant_q <= 1'b0;
      zero_drops_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      last_grant_q <= last_grant_d;
      zero_drops_q <= zero_drops_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign last_grant = last_grant_q;
  assign zero_drops = zero_drops_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a queue of expected RF-port states.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        rf_we, last_grant;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [7:0]  zero_drops;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        lg;
    logic [7:0]  zd;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        m_lg;
  int          m_zd;

  regfile_write_arbiter #(
    .DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4), .CNT_W(3)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .last_grant(last_grant), .zero_drops(zero_drops)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_waddr = '0;
    m_wdata = '0;
    m_lg    = 1'b0;
    m_zd    = 0;
    sb.delete();
  endtask

  // Called at posedge+1: drive, check readies, push expectation, clock, pop and compare.
  task automatic step(input string tag,
                      input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic er0, input logic er1);
    exp_t e;
    logic we;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #3;
    check({tag, ".ready0"}, 32'(req0_ready), 32'(er0));
    check({tag, ".ready1"}, 32'(req1_ready), 32'(er1));
    we = 1'b0;
    if (v0 && er0) begin
      m_waddr = a0; m_wdata = d0; m_lg = 1'b0; we = (a0 != 0);
      if (a0 == 0 && m_zd < 255) m_zd++;
    end else if (v1 && er1) begin
      m_waddr = a1; m_wdata = d1; m_lg = 1'b1; we = (a1 != 0);
      if (a1 == 0 && m_zd < 255) m_zd++;
    end
    sb.push_back('{we: we, waddr: m_waddr, wdata: m_wdata, lg: m_lg, zd: 8'(m_zd)});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, ".rf_we"},      32'(rf_we),      32'(e.we));
      check({tag, ".rf_waddr"},   32'(rf_waddr),   32'(e.waddr));
      check({tag, ".rf_wdata"},   rf_wdata,        e.wdata);
      check({tag, ".last_grant"}, 32'(last_grant), 32'(e.lg));
      check({tag, ".zero_drops"}, 32'(zero_drops), 32'(e.zd));
    end
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    model_reset();
    #12;
    check("rst.rf_we",      32'(rf_we),      32'd0);
    check("rst.rf_waddr",   32'(rf_waddr),   32'd0);
    check("rst.rf_wdata",   rf_wdata,        32'd0);
    check("rst.last_grant", 32'(last_grant), 32'd0);
    check("rst.zero_drops", 32'(zero_drops), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single port-0 write, then single port-1 write.
    step("t1", 1'b1, 5'd4, 32'h1234_5678, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    step("t2", 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h0000_00A5, 1'b1, 1'b1);
    check("t2.starve_cnt", 32'(dut.starve_cnt_q), 32'd0);

    // Continuous contention: four port-0 wins, then a forced port-1 grant.
    for (int i = 0; i < 4; i++) begin
      step("t3.win0", 1'b1, 5'(8 + i), 32'h1000_0000 + 32'(i),
           1'b1, 5'd9, 32'hBEEF_0001, 1'b1, 1'b0);
      check("t3.starve_cnt", 32'(dut.starve_cnt_q), (i == 3) ? 32'd0 : 32'(i + 1));
    end
    step("t3.force1", 1'b1, 5'd12, 32'h1000_0004, 1'b1, 5'd9, 32'hBEEF_0001, 1'b0, 1'b1);
    step("t3.prio0",  1'b1, 5'd12, 32'h1000_0004, 1'b1, 5'd10, 32'hBEEF_0002, 1'b1, 1'b0);
    step("t3.idle",   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);

    // Write to register 0 is accepted but dropped and counted.
    step("t4", 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

    // Protocol violation: req1 withdrawn while forced; no write, back to NORMAL.
    for (int i = 0; i < 4; i++)
      step("t5a.win0", 1'b1, 5'(16 + i), 32'h2000_0000 + 32'(i),
           1'b1, 5'd7, 32'hCAFE_0000, 1'b1, 1'b0);
    step("t5a.drop", 1'b1, 5'd20, 32'h2000_0004, 1'b0, 5'd7, 32'hCAFE_0000, 1'b0, 1'b1);
    step("t5a.norm", 1'b1, 5'd20, 32'h2000_0004, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset while forced with a write on the RF port.
    for (int i = 0; i < 4; i++)
      step("t5.win0", 1'b1, 5'(21 + i), 32'h3000_0000 + 32'(i),
           1'b1, 5'd3, 32'hD00D_0000, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    check("t5.rst.rf_we",      32'(rf_we),      32'd0);
    check("t5.rst.zero_drops", 32'(zero_drops), 32'd0);
    check("t5.rst.rf_waddr",   32'(rf_waddr),   32'd0);
    check("t5.rst.last_grant", 32'(last_grant), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5.post.ready0", 32'(req0_ready), 32'd1);
    check("t5.post.ready1", 32'(req1_ready), 32'd1);
    @(posedge clk);
    #1;
    step("t5.post.both", 1'b1, 5'd5, 32'h4000_0000, 1'b1, 5'd6, 32'h4000_0001, 1'b1, 1'b0);

    // Saturation of the register-0 drop counter.
    for (int i = 0; i < 260; i++)
      step("t6", 1'b1, 5'd0, 32'(i), 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    check("t6.zero_drops_sat", 32'(zero_drops), 32'd255);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
